// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle compare unit, one CHUNK-bit slice per cycle, MSB slice first with early exit
module cmp_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("cmp_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             valid_q, valid_d, res_q, res_d;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [WIDTH-1:0] msb, bias;
    logic             differ, eq, lt, res_calc;

    if (NCHUNK == 1) begin : g_one
        assign a_sl = a_q[CHUNK-1:0];
        assign b_sl = b_q[CHUNK-1:0];
    end else begin : g_many
        logic [NCHUNK-1:0][CHUNK-1:0] a_v, b_v;
        assign a_v  = a_q;
        assign b_v  = b_q;
        assign a_sl = a_v[idx_q];
        assign b_sl = b_v[idx_q];
    end

    // Flipping the sign bit maps signed order onto unsigned order
    assign msb      = {1'b1, {(WIDTH-1){1'b0}}};
    assign bias     = (i_op[2:1] == 2'b10) ? msb : '0;
    assign differ   = a_sl != b_sl;
    assign eq       = ~differ;
    assign lt       = a_sl < b_sl;
    assign res_calc = (op_q == 3'b000) ? eq :
                      (op_q == 3'b001) ? ~eq :
                      (op_q[2] & ~op_q[0]) ? lt :
                      (op_q[2] & op_q[0]) ? ~lt : 1'b0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (!i_flush && i_valid) begin
                a_d     = i_a ^ bias;
                b_d     = i_b ^ bias;
                op_d    = i_op;
                idx_d   = IW'(NCHUNK - 1);
                state_d = SCAN;
            end
            SCAN: if (i_flush) begin
                state_d = IDLE;
                valid_d = 1'b0;
                res_d   = 1'b0;
            end else if (differ || idx_q == '0) begin
                res_d   = res_calc;
                valid_d = 1'b1;
                state_d = DONE;
            end else begin
                idx_d = idx_q - IW'(1);
            end
            DONE: if (i_flush || i_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
                res_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign o_ready  = state_q == IDLE;
    assign o_valid  = valid_q;
    assign o_result = {{(WIDTH-1){1'b0}}, res_q};
endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed checks of cmp_seq (WIDTH=32, CHUNK=8) plus a single-slice CHUNK=32 build
module tb_cmp_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, flush = 1'b0, ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic        o_ready, o_valid;
    logic [31:0] o_result;
    logic        valid2 = 1'b0;
    logic [31:0] a2 = '0, b2 = '0;
    logic [2:0]  op2 = '0;
    logic        o_ready2, o_valid2;
    logic [31:0] o_result2;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cmp_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_a(a), .i_b(b), .i_op(op), .i_flush(flush),
        .o_valid(o_valid), .i_ready(ready), .o_result(o_result)
    );

    cmp_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_ready(o_ready2),
        .i_a(a2), .i_b(b2), .i_op(op2), .i_flush(1'b0),
        .o_valid(o_valid2), .i_ready(1'b1), .o_result(o_result2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for o_valid after the accept edge and checks latency and result without consuming
    task automatic wait_res(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int lat = 0;
        while (!o_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, o_result, exp_res);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat, input logic [31:0] exp_res);
        op = o; a = x; b = y; valid = 1'b1; ready = 1'b1;
        step();
        valid = 1'b0;
        chk({tag, "_busy"}, 32'(o_ready), 32'd0);
        wait_res(tag, exp_lat, exp_res);
        step();
        chk({tag, "_idle"}, {30'd0, o_ready, o_valid}, 32'd2);
    endtask

    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_res);
        op2 = o; a2 = x; b2 = y; valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        step();
        chk({tag, "_v"}, 32'(o_valid2), 32'd1);
        chk({tag, "_res"}, o_result2, exp_res);
        step();
        chk({tag, "_idle"}, 32'(o_ready2), 32'd1);
    endtask

    initial begin
        #3;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_result", o_result, 32'd0);
        #9 rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        step();

        run("lt_neg",   3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h1);
        run("ltu_big",  3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0);
        run("eq_same",  3'b000, 32'h1234_5678, 32'h1234_5678, 4, 32'h1);
        run("ne_same",  3'b001, 32'h1234_5678, 32'h1234_5678, 4, 32'h0);
        run("eq_lsb",   3'b000, 32'h1234_5679, 32'h1234_5678, 4, 32'h0);
        run("ge_mid",   3'b101, 32'h0000_0100, 32'h0000_00FF, 3, 32'h1);
        run("geu_top",  3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h1);
        run("ge_top",   3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h0);
        run("lt_equal", 3'b100, 32'hCAFE_0000, 32'hCAFE_0000, 4, 32'h0);
        run("rsv_010",  3'b010, 32'h0000_0005, 32'h0000_0003, 4, 32'h0);
        run("rsv_011",  3'b011, 32'h9000_0000, 32'h0000_0003, 1, 32'h0);

        // Backpressure: result held, new request ignored until IDLE
        op = 3'b000; a = 32'h1234_5678; b = 32'h1234_5678; valid = 1'b1; ready = 1'b0;
        step();
        valid = 1'b0;
        wait_res("bp", 4, 32'h1);
        op = 3'b110; a = 32'h0000_0001; b = 32'h0000_0002; valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = a ^ 32'h0100_0000;
            step();
            chk("bp_hold", {29'd0, o_valid, o_ready, o_result[0]}, 32'b101);
        end
        a = 32'h0000_0001;
        ready = 1'b1;
        step();
        chk("bp_idle", {30'd0, o_ready, o_valid}, 32'd2);
        step();
        valid = 1'b0;
        chk("bp_accept", 32'(o_ready), 32'd0);
        wait_res("bp_new", 4, 32'h1);
        step();

        // Flush in the second SCAN cycle
        op = 3'b000; a = 32'hA5A5_A5A5; b = 32'hA5A5_A5A5; valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_idle", {30'd0, o_ready, o_valid}, 32'd2);
        begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                seen += int'(o_valid);
            end
            chk("fl_novalid", 32'(seen), 32'd0);
        end

        // Flush in IDLE wins over a request
        flush = 1'b1; valid = 1'b1;
        step();
        flush = 1'b0; valid = 1'b0;
        chk("fl_idle_req", 32'(o_ready), 32'd1);

        // Asynchronous reset while in DONE
        op = 3'b100; a = 32'hFFFF_FFFF; b = 32'h0000_0001; valid = 1'b1; ready = 1'b0;
        step();
        valid = 1'b0;
        step();
        chk("ar_done", {31'd0, o_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(o_valid), 32'd0);
        chk("ar_result", o_result, 32'd0);
        #1 rst_n = 1'b1;
        chk("ar_ready", 32'(o_ready), 32'd1);
        ready = 1'b1;
        step();
        step();
        chk("ar_quiet", 32'(o_valid), 32'd0);

        // Single-slice build: every op completes one edge after accept
        run32("c32_lt",  3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1);
        run32("c32_eq",  3'b000, 32'h1234_5678, 32'h1234_5678, 32'h1);
        run32("c32_geu", 3'b111, 32'h0000_0001, 32'h0000_0002, 32'h0);
        run32("c32_rsv", 3'b010, 32'h0000_0007, 32'h0000_0003, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
- Parametrised, multi-cycle compare unit for the EX stage.
- Successor to the single-cycle 32-bit set-less-than: supports any width and six compare modes, EQ/NE/LT/GE/LTU/GEU, using RISC-V branch funct3 encoding.
- Compares one CHUNK-bit slice per cycle, most significant slice first, and finishes early at the first slice that differs. This keeps the comparator narrow for the FPGA timing path.
- Uses a valid/ready handshake on both input and output, so it can sit behind a stall-capable pipeline register.

Parameters:
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits compared per cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails. NCHUNK = WIDTH/CHUNK.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_a  in  WIDTH  operand a.
- i_b  in  WIDTH  operand b.
- i_op  in  3  000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010 and 011 are reserved.
- i_flush  in  1  abort any in-flight operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  WIDTH  compare outcome in bit 0, upper bits always 0.

Behaviour:
- Reset (i_rst_n=0, asynchronous) forces:
  - state IDLE, o_valid=0, o_result=0, o_ready=1 once released;
  - chunk index, latched operands and latched op cleared.
- A reset during SCAN or DONE discards the operation; no o_valid follows.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid=1 at a clock edge:
    - latch i_a, i_b and i_op;
    - for LT/GE, invert bit WIDTH-1 of both latched operands (signed-to-unsigned bias);
    - idx <= NCHUNK-1; go to SCAN.
- SCAN:
  - o_ready=0. Each cycle, compare a_l[idx*CHUNK +: CHUNK] with b_l[idx*CHUNK +: CHUNK] as unsigned values.
  - If the slices differ: eq=0, lt=(a slice < b slice); go to DONE.
  - Else if idx==0: eq=1, lt=0; go to DONE.
  - Else: idx <= idx-1; stay in SCAN.
- Result bit, registered on entry to DONE:
  - EQ = eq; NE = ~eq;
  - LT and LTU = lt;
  - GE and GEU = ~lt;
  - reserved ops give 0 but still complete normally.
- DONE:
  - o_valid=1; o_result and o_valid stay stable until i_ready=1.
  - On o_valid & i_ready at an edge: o_valid <= 0, o_result <= 0, go to IDLE.
  - o_ready=0 throughout DONE, so no same-cycle back-to-back acceptance.
- Latency: o_valid is visible n edges after the accept edge.
  - n = number of slices examined, from 1 (top slice differs) to NCHUNK (operands equal, or only slice 0 differs).
  - Minimum issue interval is n+2 cycles with i_ready held at 1.
- i_flush:
  - In SCAN or DONE, the next edge goes to IDLE with o_valid=0 and o_result=0; the result is dropped.
  - In IDLE, i_flush has priority over i_valid and the request is not accepted.
- i_valid in SCAN or DONE is ignored; the requester must hold the request until o_ready=1.
- CHUNK==WIDTH degenerates to a 1-slice scan with a fixed latency of 1.
- idx is $clog2(NCHUNK) bits wide, with a minimum of 1 bit. It never wraps below 0.
- Inputs are sampled only on the accept edge; later changes to i_a, i_b or i_op do not affect the in-flight result.

Test Plan:
- WIDTH=32, CHUNK=8, LT with a=0xFFFF_FFFF, b=0x0000_0001 -> o_result=0x1, o_valid 1 edge after accept. Same operands with LTU -> 0x0, same latency.
- EQ with a=b=0x1234_5678 -> 0x1 after 4 edges. NE with the same operands -> 0x0 after 4 edges. EQ with a=0x1234_5679 -> 0x0 after 4 edges.
- GE with a=0x0000_0100, b=0x0000_00FF -> 0x1 after 3 edges. GEU with a=0x8000_0000, b=0x7FFF_FFFF -> 0x1 after 1 edge. GE with the same operands -> 0x0.
- Backpressure: hold i_ready=0 for 5 cycles in DONE, pulse i_valid with new operands -> o_valid, o_result and o_ready=0 stay stable. After i_ready=1, IDLE next cycle and the new request is accepted only then.
- Flush and reset mid-operation:
  - Assert i_flush in the 2nd SCAN cycle of an equal-operand EQ -> IDLE next edge, o_valid never rises.
  - Drive i_rst_n=0 asynchronously in DONE -> o_valid and o_result go to 0 immediately.
- Reserved op 010 with any operands -> completes with o_result=0x0 and normal handshake. Rebuild with CHUNK=32 -> every op completes in 1 edge.
